fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the RV32I pipeline. It owns the program counter and drives the word address into the combinational instruction memory.
- It captures the returned instruction word into the IF/ID pipeline register.
- It handles stall, branch/jump redirect (flush) and halt-on-EBREAK with a drain window for wrong-path EBREAKs.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- ADDR_W, 8, instruction memory word-address width.
- DRAIN_CYCLES, 2, non-stalled cycles to wait after EBREAK fetch before halting (covers ID/EX redirect latency).
- NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  hazard hold: PC and IF/ID keep their values
- redirect_valid  input  1  taken branch/jump resolved downstream
- redirect_target  input  32  new PC (byte address)
- imem_addr  output  ADDR_W  word address to instruction memory = pc[ADDR_W+1:2]
- imem_data  input  32  instruction word, combinational, same cycle as imem_addr
- ifid_pc  output  32  PC of instruction in IF/ID
- ifid_pc_plus4  output  32  ifid_pc + 4
- ifid_inst  output  32  instruction in IF/ID
- ifid_valid  output  1  1 = real instruction, 0 = bubble
- halted  output  1  core halted after EBREAK
- pc_out  output  32  current fetch PC (debug)

Behaviour:
- Reset (rst=1 at edge, any state): pc=RESET_PC; ifid_pc=0; ifid_pc_plus4=4; ifid_inst=NOP_INST; ifid_valid=0; halted=0; state=RUN; drain_cnt=0. Reset mid-DRAIN or in HALT returns to RUN.
- Latency: the instruction at pc appears in IF/ID one edge later. No other buffering.
- Edge priority: rst > redirect_valid > stall > normal.
- Address arithmetic: pc+4 is modulo 2^32. imem_addr truncates, so the fetch wraps to word 0 beyond 4*2^ADDR_W. redirect_target[1:0] is forced to 00.
- States:
  - RUN, normal edge: pc<=pc+4; IF/ID<={pc, pc+4, imem_data, 1}. If imem_data==32'h00100073 (EBREAK), the same update happens, then state<=DRAIN and drain_cnt<=DRAIN_CYCLES.
  - RUN, stall: all registers hold.
  - RUN, redirect (stall ignored): pc<=target; IF/ID<={0, 4, NOP_INST, 0}.
  - DRAIN: pc frozen and fetches suppressed. Each non-stalled edge without redirect: IF/ID<=bubble and drain_cnt-=1; when drain_cnt==1 at the edge, state<=HALT. Stall holds everything, including drain_cnt. Redirect (EBREAK was on the wrong path): pc<=target, IF/ID<=bubble, state<=RUN.
  - HALT: halted=1; pc frozen; IF/ID bubble each edge; redirect and stall ignored. Only rst exits.
- halted is registered: it asserts on the edge that enters HALT.

Test Plan:
- Sequential fetch (program mem[0]=0x00000013, mem[1]=0x00100093, mem[2]=0x00500093): release rst -> edges 1..3 give ifid_pc 0x0/0x4/0x8, ifid_inst 0x00000013/0x00100093/0x00500093, ifid_valid=1, imem_addr 0,1,2 then 3.
- Stall: stall=1 for 2 cycles while pc=0x10 -> pc, ifid_* unchanged for 2 edges; next edge ifid_pc=0x10, pc=0x14.
- Redirect+stall together: stall=1, redirect_valid=1, target=0x8E -> pc=0x8C, ifid_valid=0, ifid_inst=0x00000013; next edge ifid_pc=0x8C, inst=mem[35].
- Halt: redirect to 0xFC where mem[63]=0x00100073 -> edge1 ifid_inst=0x00100073, pc=0x100; edges 2,3 bubbles; halted=1 after edge3; pc stays 0x100; later redirect ignored.
- Wrong-path EBREAK: EBREAK fetched, redirect_valid=1, target=0x40 on the first DRAIN edge -> state RUN, pc=0x40, halted stays 0; fetch resumes at word 16.
- Reset in DRAIN/HALT: rst=1 for 1 edge -> pc=0, halted=0, ifid_valid=0; normal fetch resumes.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage connection bundle: downstream control, instruction memory port and IF/ID outputs.
// The master modport is the fetch stage; the slave modport is its surroundings.
interface fetch_if #(
  parameter int ADDR_W = 8
);
  logic              stall;
  logic              redirect_valid;
  logic [31:0]       redirect_target;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic [31:0]       ifid_pc;
  logic [31:0]       ifid_pc_plus4;
  logic [31:0]       ifid_inst;
  logic              ifid_valid;
  logic              halted;
  logic [31:0]       pc_out;

  modport master (
    input  stall, redirect_valid, redirect_target, imem_data,
    output imem_addr, ifid_pc, ifid_pc_plus4, ifid_inst, ifid_valid, halted, pc_out
  );

  modport slave (
    output stall, redirect_valid, redirect_target, imem_data,
    input  imem_addr, ifid_pc, ifid_pc_plus4, ifid_inst, ifid_valid, halted, pc_out
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, fills the IF/ID register, and halts after EBREAK
// once a short drain window has shown that no older branch/jump redirected it away.
module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h00000000,
  parameter int          ADDR_W       = 8,
  parameter int          DRAIN_CYCLES = 2,
  parameter logic [31:0] NOP_INST     = 32'h00000013
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);
  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam int          CNT_W  = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_drain_cnt;
  logic [31:0]        r_pc;
  logic [31:0]        r_ifid_pc;
  logic [31:0]        r_ifid_pc4;
  logic [31:0]        r_ifid_inst;
  logic               r_ifid_valid;
  logic               r_halted;
  logic [31:0]        w_pc_plus4;
  logic [31:0]        w_target;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_target   = bus.redirect_target & ~32'h3;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_drain_cnt  <= '0;
      r_pc         <= RESET_PC;
      r_ifid_pc    <= 32'd0;
      r_ifid_pc4   <= 32'd4;
      r_ifid_inst  <= NOP_INST;
      r_ifid_valid <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (bus.redirect_valid) begin
            r_pc         <= w_target;
            r_ifid_pc    <= 32'd0;
            r_ifid_pc4   <= 32'd4;
            r_ifid_inst  <= NOP_INST;
            r_ifid_valid <= 1'b0;
          end else if (!bus.stall) begin
            r_pc         <= w_pc_plus4;
            r_ifid_pc    <= r_pc;
            r_ifid_pc4   <= w_pc_plus4;
            r_ifid_inst  <= bus.imem_data;
            r_ifid_valid <= 1'b1;
            if (bus.imem_data == EBREAK) begin
              r_state     <= DRAIN;
              r_drain_cnt <= CNT_W'(DRAIN_CYCLES);
            end
          end
        end
        DRAIN: begin
          // A redirect here means the EBREAK was fetched down a mispredicted path.
          if (bus.redirect_valid) begin
            r_pc         <= w_target;
            r_ifid_pc    <= 32'd0;
            r_ifid_pc4   <= 32'd4;
            r_ifid_inst  <= NOP_INST;
            r_ifid_valid <= 1'b0;
            r_state      <= RUN;
          end else if (!bus.stall) begin
            r_ifid_pc    <= 32'd0;
            r_ifid_pc4   <= 32'd4;
            r_ifid_inst  <= NOP_INST;
            r_ifid_valid <= 1'b0;
            r_drain_cnt  <= r_drain_cnt - CNT_W'(1);
            if (r_drain_cnt == CNT_W'(1)) begin
              r_state  <= HALT;
              r_halted <= 1'b1;
            end
          end
        end
        default: begin
          r_ifid_pc    <= 32'd0;
          r_ifid_pc4   <= 32'd4;
          r_ifid_inst  <= NOP_INST;
          r_ifid_valid <= 1'b0;
          r_halted     <= 1'b1;
        end
      endcase
    end
  end

  assign bus.imem_addr     = r_pc[ADDR_W+1:2];
  assign bus.ifid_pc       = r_ifid_pc;
  assign bus.ifid_pc_plus4 = r_ifid_pc4;
  assign bus.ifid_inst     = r_ifid_inst;
  assign bus.ifid_valid    = r_ifid_valid;
  assign bus.halted        = r_halted;
  assign bus.pc_out        = r_pc;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall, redirect, halt, wrong-path EBREAK,
// reset from DRAIN/HALT and address wrap, with a combinational instruction memory model.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] EBK = 32'h00100073;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  fetch_if #(.ADDR_W(8)) bus ();

  fetch_stage #(
    .RESET_PC(32'h00000000), .ADDR_W(8), .DRAIN_CYCLES(2), .NOP_INST(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  assign bus.imem_data = mem[bus.imem_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h10000000 | (i << 7) | 32'h33;
    mem[0]  = 32'h00000013;
    mem[1]  = 32'h00100093;
    mem[2]  = 32'h00500093;
    mem[20] = EBK;
    mem[63] = EBK;

    rst = 1'b1; bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = 32'h0;
    step(); step();
    chk("rst_pc", bus.pc_out, 32'h0);
    chk("rst_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("rst_inst", bus.ifid_inst, NOP);
    chk("rst_pc4", bus.ifid_pc_plus4, 32'd4);
    chk("rst_ifid_pc", bus.ifid_pc, 32'd0);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    chk("rst_addr", {24'd0, bus.imem_addr}, 32'd0);

    // Sequential fetch
    rst = 1'b0;
    step();
    chk("seq1_pc", bus.ifid_pc, 32'h0);
    chk("seq1_inst", bus.ifid_inst, 32'h00000013);
    chk("seq1_valid", {31'd0, bus.ifid_valid}, 32'd1);
    chk("seq1_addr", {24'd0, bus.imem_addr}, 32'd1);
    step();
    chk("seq2_pc", bus.ifid_pc, 32'h4);
    chk("seq2_inst", bus.ifid_inst, 32'h00100093);
    chk("seq2_pc4", bus.ifid_pc_plus4, 32'h8);
    chk("seq2_addr", {24'd0, bus.imem_addr}, 32'd2);
    step();
    chk("seq3_pc", bus.ifid_pc, 32'h8);
    chk("seq3_inst", bus.ifid_inst, 32'h00500093);
    chk("seq3_addr", {24'd0, bus.imem_addr}, 32'd3);
    step();
    chk("seq4_pcout", bus.pc_out, 32'h10);

    // Stall two edges at pc=0x10
    bus.stall = 1'b1;
    step();
    chk("stall1_pc", bus.pc_out, 32'h10);
    chk("stall1_ifid", bus.ifid_pc, 32'hC);
    step();
    chk("stall2_pc", bus.pc_out, 32'h10);
    chk("stall2_inst", bus.ifid_inst, mem[3]);
    bus.stall = 1'b0;
    step();
    chk("unstall_ifid", bus.ifid_pc, 32'h10);
    chk("unstall_pc", bus.pc_out, 32'h14);
    chk("unstall_inst", bus.ifid_inst, mem[4]);

    // Redirect wins over stall; low target bits cleared
    bus.stall = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_target = 32'h8E;
    step();
    chk("redir_pc", bus.pc_out, 32'h8C);
    chk("redir_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("redir_inst", bus.ifid_inst, NOP);
    chk("redir_ifid_pc", bus.ifid_pc, 32'h0);
    bus.stall = 1'b0; bus.redirect_valid = 1'b0;
    step();
    chk("redir2_ifid", bus.ifid_pc, 32'h8C);
    chk("redir2_inst", bus.ifid_inst, mem[35]);
    chk("redir2_pc", bus.pc_out, 32'h90);

    // Wrong-path EBREAK at 0x50, redirected on first DRAIN edge
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h50;
    step();
    bus.redirect_valid = 1'b0;
    step();
    chk("wp_inst", bus.ifid_inst, EBK);
    chk("wp_pc", bus.pc_out, 32'h54);
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h40;
    step();
    chk("wp_redir_pc", bus.pc_out, 32'h40);
    chk("wp_redir_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("wp_halted", {31'd0, bus.halted}, 32'd0);
    bus.redirect_valid = 1'b0;
    step();
    chk("wp_resume_pc", bus.ifid_pc, 32'h40);
    chk("wp_resume_inst", bus.ifid_inst, mem[16]);
    chk("wp_resume_valid", {31'd0, bus.ifid_valid}, 32'd1);
    step(); step();
    chk("wp_still_run", {31'd0, bus.halted}, 32'd0);

    // Real halt at 0xFC, with a stall inside the drain window
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'hFC;
    step();
    bus.redirect_valid = 1'b0;
    step();
    chk("h1_inst", bus.ifid_inst, EBK);
    chk("h1_pc", bus.pc_out, 32'h100);
    chk("h1_halted", {31'd0, bus.halted}, 32'd0);
    bus.stall = 1'b1;
    step();
    chk("hstall_inst", bus.ifid_inst, EBK);
    chk("hstall_halted", {31'd0, bus.halted}, 32'd0);
    bus.stall = 1'b0;
    step();
    chk("h2_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("h2_halted", {31'd0, bus.halted}, 32'd0);
    chk("h2_pc", bus.pc_out, 32'h100);
    step();
    chk("h3_halted", {31'd0, bus.halted}, 32'd1);
    chk("h3_pc", bus.pc_out, 32'h100);
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h40;
    step();
    chk("hredir_pc", bus.pc_out, 32'h100);
    chk("hredir_halted", {31'd0, bus.halted}, 32'd1);
    chk("hredir_valid", {31'd0, bus.ifid_valid}, 32'd0);
    bus.redirect_valid = 1'b0;

    // Reset from HALT
    rst = 1'b1;
    step();
    chk("rh_pc", bus.pc_out, 32'h0);
    chk("rh_halted", {31'd0, bus.halted}, 32'd0);
    chk("rh_valid", {31'd0, bus.ifid_valid}, 32'd0);
    rst = 1'b0;
    step();
    chk("rh_fetch_inst", bus.ifid_inst, mem[0]);
    chk("rh_fetch_valid", {31'd0, bus.ifid_valid}, 32'd1);

    // Reset from DRAIN
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h50;
    step();
    bus.redirect_valid = 1'b0;
    step();
    chk("rd_ebreak", bus.ifid_inst, EBK);
    rst = 1'b1;
    step();
    chk("rd_pc", bus.pc_out, 32'h0);
    chk("rd_valid", {31'd0, bus.ifid_valid}, 32'd0);
    rst = 1'b0;
    step(); step(); step();
    chk("rd_run_pc", bus.ifid_pc, 32'h8);
    chk("rd_run_valid", {31'd0, bus.ifid_valid}, 32'd1);
    chk("rd_run_halted", {31'd0, bus.halted}, 32'd0);

    // Fetch address wraps past the last memory word
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h3FC;
    step();
    chk("wrap_addr_hi", {24'd0, bus.imem_addr}, 32'd255);
    bus.redirect_valid = 1'b0;
    step();
    chk("wrap_inst", bus.ifid_inst, mem[255]);
    chk("wrap_pc", bus.pc_out, 32'h400);
    chk("wrap_addr", {24'd0, bus.imem_addr}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
